// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encodings.
package nibble_add_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_adder.sv
// One 4-bit ripple-carry slice built from four one-bit full adders.
// c3 is the carry into bit 3, tapped so the controller can form signed overflow.
module nibble_adder
  import nibble_add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] sum,
  output logic                co,
  output logic                c3
);

  logic c1;
  logic c2;

  assign sum[0] = a[0] ^ b[0] ^ ci;
  assign c1     = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c1;
  assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  assign sum[2] = a[2] ^ b[2] ^ c2;
  assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
  assign sum[3] = a[3] ^ b[3] ^ c3;
  assign co     = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit slice, LS nibble first.
// Optional subtract support is compiled in with the NIBBLE_ADD_SUB_EN macro.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE (and low while reset is asserted);
// out_valid is high only in DONE, and result/carry/overflow stay frozen until
// the consumer takes the beat. No same-cycle turnaround from DONE to accept.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             ci,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0]    b_cap;
  logic                cin_cap;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_co;
  logic                slice_c3;

  // Select the second operand and initial carry that get captured on accept.
`ifdef NIBBLE_ADD_SUB_EN
  always_comb begin
    b_cap   = op_sub ? ~r2 : r2;
    cin_cap = op_sub ? 1'b1 : ci;
  end
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  always_comb begin
    b_cap   = r2;
    cin_cap = ci;
  end
`endif

  // Operands are shifted right each RUN cycle, so the slice always sees bits [3:0].
  nibble_adder u_slice (
    .a   (a_q[NIBBLE_W-1:0]),
    .b   (b_q[NIBBLE_W-1:0]),
    .ci  (cr_q),
    .sum (slice_sum),
    .co  (slice_co),
    .c3  (slice_c3)
  );

  // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    cr_d       = cr_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          idx_d   = '0;
          a_d     = r1;
          b_d     = b_cap;
          cr_d    = cin_cap;
        end
      end
      ST_RUN: begin
        // Result fills from the top: after NIBBLES shifts nibble 0 sits at [3:0].
        result_d = {slice_sum, result_q[WIDTH-1:NIBBLE_W]};
        a_d      = a_q >> NIBBLE_W;
        b_d      = b_q >> NIBBLE_W;
        cr_d     = slice_co;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_d    = slice_co;
          overflow_d = slice_co ^ slice_c3;
          idx_d      = '0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cr_q       <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cr_q       <= cr_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed testbench for nibble_add_seq (WIDTH=16). Expectations are hand-computed.
// Honours NIBBLE_ADD_SUB_EN for the subtract expectations.
module tb_nibble_add_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic         ci;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r1        (r1),
    .r2        (r2),
    .ci        (ci),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
    r1       = a;
    r2       = b;
    ci       = c;
    op_sub   = s;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r1 = '0; r2 = '0; ci = 1'b0; op_sub = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || carry !== 1'b0 || overflow !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%h c=%b o=%b st=%0d exp v=0 r=0000 c=0 o=0 st=0",
               out_valid, result, carry, overflow, dbg_state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  // One op: accept, wait for result with latency check, scribble inputs meanwhile, then handshake.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s,
                        input logic [W-1:0] exp_r, input logic exp_c, input logic exp_o);
    int n;
    drive_op(a, b, c, s);
    tick();
    n = 0;
    while (n < 20) begin
      r1 = W'($urandom_range(0, 16'hFFFF));
      r2 = W'($urandom_range(0, 16'hFFFF));
      ci = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (out_valid === 1'b1) break;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", name, n); end
    checks++;
    if (result !== exp_r || carry !== exp_c || overflow !== exp_o) begin
      errors++;
      $display("FAIL %s_value got r=%h c=%b o=%b exp r=%h c=%b o=%b",
               name, result, carry, overflow, exp_r, exp_c, exp_o);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_done_in_ready got=%b exp=0", name, in_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake got v=%b rdy=%b exp v=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_add_vectors();
    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf_ci", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("add_alt", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
`ifdef NIBBLE_ADD_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`else
    run_op("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
    run_op("sub_ignored2", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    drive_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    tick();               // accepted, idx=0
    in_valid = 1'b0;
    tick();               // idx=1
    tick();               // idx=2
    checks++;
    if (dbg_state !== 2'd1) begin errors++; $display("FAIL midrun_state got=%0d exp=1", dbg_state); end
    reset = 1'b1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got st=%0d v=%b r=%h rdy=%b exp st=0 v=0 r=0000 rdy=0",
               dbg_state, out_valid, result, in_ready);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    drive_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (n < 20 && out_valid !== 1'b1) begin tick(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got v=%b exp v=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      r1 = W'($urandom_range(0, 16'hFFFF));
      r2 = W'($urandom_range(0, 16'hFFFF));
      in_valid = ~in_valid;
      tick();
      checks++;
      if (result !== 16'h1010 || carry !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got r=%h c=%b o=%b v=%b rdy=%b exp r=1010 c=0 o=0 v=1 rdy=0",
                 i, result, carry, overflow, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got st=%0d v=%b rdy=%b exp st=0 v=0 rdy=1", dbg_state, out_valid, in_ready);
    end
    // out_ready with nothing to deliver must leave the block idle.
    tick();
    tick();
    out_ready = 1'b0;
    checks++;
    if (dbg_state !== 2'd0 || out_valid !== 1'b0 || result !== 16'h1010) begin
      errors++;
      $display("FAIL idle_out_ready got st=%0d v=%b r=%h exp st=0 v=0 r=1010", dbg_state, out_valid, result);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    drive_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    tick();
    drive_op(16'h1000, 16'h0FFF, 1'b1, 1'b0);  // next op offered while busy
    n = 0;
    while (n < 20) begin tick(); n++; if (out_valid === 1'b1) break; end
    checks++;
    if (n !== 4 || result !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_first got n=%0d r=%h exp n=4 r=0003", n, result);
    end
    tick();   // handshake edge
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_turnaround got rdy=%b exp=1", in_ready); end
    tick();   // second accept
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin tick(); n++; if (out_valid === 1'b1) break; end
    checks++;
    if (n !== 4 || result !== 16'h2000 || carry !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got n=%0d r=%h c=%b o=%b exp n=4 r=2000 c=0 o=0", n, result, carry, overflow);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_sub();
    test_reset_mid_run();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
